// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NREQ byte requesters share one
// UART transmitter. A packet (bytes up to and including req_last) keeps the grant
// until it finishes. tx_start, tx_data and req_ready are registered, so the
// start/consume pulse appears in the cycle after the SEND decision.
// Build option: define UART_TX_ARB_TAG_EN to send a tag byte 8'hA0 | grant_id
// in front of every packet.
module uart_tx_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [2:0]        grant_id,
    output logic              locked
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TAG     = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    state_t          stateR;
    state_t          stateNextS;
    logic [2:0]      ptrR;
    logic            waitCntR;
    logic            waitCntNextS;
    logic            tagPendR;
    logic            tagPendNextS;
    logic [NREQ-1:0] eligS;
    logic [3:0]      winS;
    logic [IW-1:0]   gIdxS;
    logic            grantLoadS;
    logic            consumeS;
    logic            startS;
    logic [7:0]      dataS;
    logic [NREQ-1:0] readyS;

    // Round-robin search: first eligible requester after 'start', wrapping.
    // Returns {found, index}.
    function automatic logic [3:0] pickWinner(input logic [NREQ-1:0] elig,
                                              input logic [2:0]      start);
        logic [3:0] res;
        int         idx;
        res = 4'b0000;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(start) + k) % NREQ;
            if (elig[IW'(idx)]) begin
                res = {1'b1, 3'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign gIdxS = grant_id[IW-1:0];

    // Eligible set: everyone when unlocked, only the holder while a packet is open.
    always_comb begin
        eligS = {NREQ{1'b0}};
        if (locked) begin
            eligS[gIdxS] = req_valid[gIdxS];
        end else begin
            eligS = req_valid;
        end
        winS = pickWinner(eligS, ptrR);
    end

    // Next-state and pulse decisions for the arbiter FSM.
    always_comb begin
        stateNextS   = stateR;
        waitCntNextS = waitCntR;
        tagPendNextS = tagPendR;
        grantLoadS   = 1'b0;
        consumeS     = 1'b0;
        startS       = 1'b0;
        dataS        = 8'h00;
        readyS       = {NREQ{1'b0}};
        case (stateR)
            IDLE: begin
                if (!tx_busy && winS[3]) begin
                    grantLoadS = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                    if (!locked) begin
                        stateNextS = TAG;
                    end else begin
                        stateNextS = SEND;
                    end
`else
                    stateNextS = SEND;
`endif
                end else begin
                    stateNextS = IDLE;
                end
            end
            TAG: begin
                startS       = 1'b1;
                dataS        = 8'hA0 | {5'b00000, grant_id};
                tagPendNextS = 1'b1;
                waitCntNextS = 1'b0;
                stateNextS   = WAIT_HI;
            end
            SEND: begin
                tagPendNextS = 1'b0;
                if (req_valid[gIdxS]) begin
                    startS         = 1'b1;
                    dataS          = req_data[{gIdxS, 3'b000} +: 8];
                    readyS[gIdxS]  = 1'b1;
                    consumeS       = 1'b1;
                    waitCntNextS   = 1'b0;
                    stateNextS     = WAIT_HI;
                end else begin
                    // Requester withdrew its byte: drop the slot silently.
                    stateNextS = IDLE;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    stateNextS = WAIT_LO;
                end else if (waitCntR) begin
                    // Busy never seen: the transmitter finished within one tick.
                    stateNextS = tagPendR ? SEND : IDLE;
                end else begin
                    waitCntNextS = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    stateNextS = tagPendR ? SEND : IDLE;
                end else begin
                    stateNextS = WAIT_LO;
                end
            end
            default: begin
                stateNextS   = IDLE;
                tagPendNextS = 1'b0;
            end
        endcase
    end

    // State, pointer, grant/lock bookkeeping and registered transmitter outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR    <= IDLE;
            ptrR      <= 3'(NREQ - 1);
            waitCntR  <= 1'b0;
            tagPendR  <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            req_ready <= {NREQ{1'b0}};
            grant_id  <= 3'd0;
            locked    <= 1'b0;
        end else begin
            stateR    <= stateNextS;
            waitCntR  <= waitCntNextS;
            tagPendR  <= tagPendNextS;
            tx_start  <= startS;
            req_ready <= readyS;
            if (startS) begin
                tx_data <= dataS;
            end
            if (grantLoadS) begin
                grant_id <= winS[2:0];
            end
            if (consumeS) begin
                locked <= ~req_last[gIdxS];
                if (req_last[gIdxS]) begin
                    ptrR <= grant_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes requester bytes and the
// expected transmit sequence; a negedge monitor pops and compares on each tx_start.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;

    typedef struct packed {
        logic [2:0] g;
        logic [7:0] data;
        logic [3:0] ready;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic [2:0]        grant_id;
    logic              locked;

    logic [8:0] rq [NREQ][$];
    exp_t       expQ [$];
    exp_t       monE;
    logic [3:0] glitch = 4'b0000;
    int         busyCnt = 0;
    int         compared = 0;
    int         mismatched = 0;

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] qValid();
        logic [3:0] r = 4'b0000;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] qData();
        logic [31:0] r = 32'h0;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) r[8*i +: 8] = rq[i][0][7:0];
        return r;
    endfunction

    function automatic logic [3:0] qLast();
        logic [3:0] r = 4'b0000;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) r[i] = rq[i][0][8];
        return r;
    endfunction

    // Requesters: pop the front byte when consumed, present the next one.
    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        req_valid <= qValid() | glitch;
        req_data  <= qData();
        req_last  <= qLast();
    end

    // Transmitter model: busy for 6 cycles starting the cycle after tx_start.
    always @(posedge clk) begin
        if (tx_start && busyCnt == 0) begin
            tx_busy <= 1'b1;
            busyCnt <= 6;
        end else if (busyCnt > 1) begin
            busyCnt <= busyCnt - 1;
        end else if (busyCnt == 1) begin
            busyCnt <= 0;
            tx_busy <= 1'b0;
        end
    end

    // Monitor: compare each transmitted byte with the scoreboard, check pulse rules.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != 4'b0000 && !tx_start) begin
                compared++; mismatched++;
                $display("FAIL ready_without_start: req_ready=%b, required 0000", req_ready);
            end
            if (tx_start) begin
                if (tx_busy) begin
                    compared++; mismatched++;
                    $display("FAIL start_while_busy: tx_start=1 with tx_busy=1, required no start");
                end
                if (expQ.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_start: tx_data=%h grant=%0d, required no tx_start", tx_data, grant_id);
                end else begin
                    monE = expQ.pop_front();
                    compared++;
                    if (tx_data !== monE.data || req_ready !== monE.ready || grant_id !== monE.g) begin
                        mismatched++;
                        $display("FAIL tx_byte: got data=%h ready=%b grant=%0d, required data=%h ready=%b grant=%0d",
                                 tx_data, req_ready, grant_id, monE.data, monE.ready, monE.g);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic checkReset(input string name);
        check({name, "_tx_start"}, {7'd0, tx_start}, 8'h00);
        check({name, "_tx_data"}, tx_data, 8'h00);
        check({name, "_req_ready"}, {4'd0, req_ready}, 8'h00);
        check({name, "_grant_id"}, {5'd0, grant_id}, 8'h00);
        check({name, "_locked"}, {7'd0, locked}, 8'h00);
    endtask

    task automatic expByte(input int g, input logic [7:0] d, input logic first);
        exp_t e;
`ifdef UART_TX_ARB_TAG_EN
        if (first) begin
            e.g = 3'(g); e.data = 8'hA0 | {5'b00000, 3'(g)}; e.ready = 4'b0000;
            expQ.push_back(e);
        end
`endif
        e.g = 3'(g); e.data = d; e.ready = 4'b0001 << g;
        expQ.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            n++;
            if (expQ.size() == 0 && !tx_busy && !tx_start && qValid() == 4'b0000 && req_valid == 4'b0000)
                quiet++;
            else
                quiet = 0;
        end
        compared++;
        if (quiet < 4) begin
            mismatched++;
            $display("FAIL %s_drain: not idle after %0d cycles, %0d expected bytes left, required 0",
                     name, n, expQ.size());
        end
    endtask

    task automatic doReset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;

        // Single byte from requester 0.
        rq[0].push_back({1'b1, 8'h55}); expByte(0, 8'h55, 1'b1);
        drain("single", 400);

        // All four valid after reset: order 0,1,2,3 then 0 again.
        doReset();
        rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h20});
        rq[1].push_back({1'b1, 8'h11});
        rq[2].push_back({1'b1, 8'h12});
        rq[3].push_back({1'b1, 8'h13});
        expByte(0, 8'h10, 1'b1); expByte(1, 8'h11, 1'b1); expByte(2, 8'h12, 1'b1);
        expByte(3, 8'h13, 1'b1); expByte(0, 8'h20, 1'b1);
        drain("rotate", 800);

        // Requester 2 holds the grant for a 3-byte packet while 0 and 1 wait.
        rq[1].push_back({1'b1, 8'h31}); rq[1].push_back({1'b1, 8'h32});
        rq[2].push_back({1'b0, 8'h2A}); rq[2].push_back({1'b0, 8'h2B}); rq[2].push_back({1'b1, 8'h2C});
        rq[0].push_back({1'b1, 8'h01});
        expByte(1, 8'h31, 1'b1); expByte(2, 8'h2A, 1'b1); expByte(2, 8'h2B, 1'b0);
        expByte(2, 8'h2C, 1'b0); expByte(0, 8'h01, 1'b1); expByte(1, 8'h32, 1'b1);
        drain("packet", 1200);

        // Two-byte packet from requester 1 (tag-prefixed in the tag build).
        rq[1].push_back({1'b0, 8'h44}); rq[1].push_back({1'b1, 8'h45});
        expByte(1, 8'h44, 1'b1); expByte(1, 8'h45, 1'b0);
        drain("two_byte", 600);

        // Reset during WAIT_LO of a locked packet from requester 3.
        rq[3].push_back({1'b0, 8'h71}); rq[3].push_back({1'b1, 8'h72});
        expByte(3, 8'h71, 1'b1);
        n = 0;
        while (!(tx_busy && locked) && n < 200) begin @(negedge clk); n++; end
        check("locked_before_rst", {7'd0, locked}, 8'h01);
        #2 rst = 1'b1;
        rq[3].delete();
        expQ.delete();
        @(negedge clk);
        checkReset("mid_rst");
        rq[3].push_back({1'b1, 8'h73});
        rq[0].push_back({1'b1, 8'h09});
        expByte(0, 8'h09, 1'b1); expByte(3, 8'h73, 1'b1);
        @(negedge clk); rst = 1'b0;
        drain("after_rst", 800);

        // Requester 2 withdraws its byte in the SEND cycle: no data byte, no consume.
`ifdef UART_TX_ARB_TAG_EN
        begin
            exp_t t;
            t.g = 3'd2; t.data = 8'hA2; t.ready = 4'b0000;
            expQ.push_back(t);
        end
`endif
        @(negedge clk); glitch = 4'b0100;
        @(negedge clk); glitch = 4'b0000;
        drain("withdraw", 400);
        check("withdraw_grant", {5'd0, grant_id}, 8'h02);
        check("withdraw_locked", {7'd0, locked}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
